// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage_pkg
//  Description : Shared widths, bus layouts, stall encoding, ALU/operand-select
//                bit positions and DIV/DIVU decode for the execute stage.
//  Revision    : 1.0  initial release
// ============================================================================
package ex_stage_pkg;

    localparam int c_id_to_ex_wd  = 159;
    localparam int c_ex_to_mem_wd = 142;
    localparam int c_ex_to_rf_wd  = 38;
    localparam int c_stall_wd     = 6;

    // Stall bus encoding: one bit per pipeline stage
    localparam logic c_stop    = 1'b1;
    localparam logic c_no_stop = 1'b0;

    // R-type function codes for the divides (opcode field is zero)
    localparam logic [5:0] c_func_div  = 6'h1A;
    localparam logic [5:0] c_func_divu = 6'h1B;

    // Bit positions inside the one-hot alu_op field
    localparam int c_alu_add  = 11;
    localparam int c_alu_sub  = 10;
    localparam int c_alu_slt  = 9;
    localparam int c_alu_sltu = 8;
    localparam int c_alu_and  = 7;
    localparam int c_alu_nor  = 6;
    localparam int c_alu_or   = 5;
    localparam int c_alu_xor  = 4;
    localparam int c_alu_sll  = 3;
    localparam int c_alu_srl  = 2;
    localparam int c_alu_sra  = 1;
    localparam int c_alu_lui  = 0;

    // Bit positions inside the one-hot operand selects
    localparam int c_src1_rs   = 0;
    localparam int c_src1_pc   = 1;
    localparam int c_src1_sa   = 2;
    localparam int c_src2_rt   = 0;
    localparam int c_src2_simm = 1;
    localparam int c_src2_8    = 2;
    localparam int c_src2_zimm = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  src1;
        logic [3:0]  src2;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] result;
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
    } ex_mem_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } ex_rf_t;

    function automatic logic is_div_inst(input logic [31:0] inst);
        return (inst[31:26] == 6'h00) &&
               ((inst[5:0] == c_func_div) || (inst[5:0] == c_func_divu));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_div.sv
`default_nettype none
// ============================================================================
//  Module      : div_r2
//  Description : Iterative radix-2 restoring divider, one quotient bit per
//                cycle. Signed operation divides magnitudes and fixes signs
//                at the end; divide-by-zero returns all-ones / dividend.
//  Revision    : 1.0  initial release
// ============================================================================
module div_r2 #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_signed,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_ack,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_q,
    output logic [31:0] o_r
);

    localparam int                 c_cnt_w    = $clog2(DIV_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DIV_CYCLES - 1);

    localparam logic [1:0] c_s_idle = 2'd0;
    localparam logic [1:0] c_s_run  = 2'd1;
    localparam logic [1:0] c_s_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [31:0]        r_rem;
    logic [31:0]        r_quo;
    logic [31:0]        r_dvs;
    logic [31:0]        r_dvd;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_b_zero;

    logic [31:0]        w_a_mag;
    logic [31:0]        w_b_mag;
    logic [32:0]        w_trial;
    logic [31:0]        w_q_fix;
    logic [31:0]        w_r_fix;

    assign w_a_mag = (i_signed && i_a[31]) ? (32'd0 - i_a) : i_a;
    assign w_b_mag = (i_signed && i_b[31]) ? (32'd0 - i_b) : i_b;

    // Partial remainder with the next dividend bit shifted in, minus divisor;
    // bit 32 set means the subtraction borrowed and the step is restored.
    assign w_trial = {r_rem, r_quo[31]} - {1'b0, r_dvs};

    assign w_q_fix = r_neg_q ? (32'd0 - r_quo) : r_quo;
    assign w_r_fix = r_neg_r ? (32'd0 - r_rem) : r_rem;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: start on a divide, run DIV_CYCLES steps, wait for ack
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_s_idle: if (i_start)              w_next = c_s_run;
            c_s_run:  if (r_cnt == c_cnt_last)  w_next = c_s_done;
            c_s_done: if (i_ack)                w_next = c_s_idle;
            default:                            w_next = c_s_idle;
        endcase
    end

    // Outputs: busy covers the capture cycle and every run cycle
    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        o_q    = '0;
        o_r    = '0;
        case (r_state)
            c_s_idle: o_busy = i_start;
            c_s_run:  o_busy = 1'b1;
            c_s_done: begin
                o_done = 1'b1;
                o_q    = r_b_zero ? 32'hFFFF_FFFF : w_q_fix;
                o_r    = r_b_zero ? r_dvd         : w_r_fix;
            end
            default: ;
        endcase
    end

    // Datapath: capture operands on start, one restoring step per run cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_dvd    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
        end else if (r_state == c_s_idle && i_start) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= w_a_mag;
            r_dvs    <= w_b_mag;
            r_dvd    <= i_a;
            r_neg_q  <= i_signed & (i_a[31] ^ i_b[31]);
            r_neg_r  <= i_signed & i_a[31];
            r_b_zero <= (i_b == 32'd0);
        end else if (r_state == c_s_run) begin
            r_cnt <= r_cnt + 1'b1;
            if (!w_trial[32]) begin
                r_rem <= w_trial[31:0];
                r_quo <= {r_quo[30:0], 1'b1};
            end else begin
                r_rem <= {r_rem[30:0], r_quo[31]};
                r_quo <= {r_quo[30:0], 1'b0};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage
//  Description : MIPS execute stage: ID/EX pipeline register, inline ALU,
//                data-SRAM request, EX->decode forwarding and DIV/DIVU via
//                the iterative divider with pipeline stall request.
//  Revision    : 1.0  initial release
// ============================================================================
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [c_stall_wd-1:0]     stall,
    input  logic [c_id_to_ex_wd-1:0]  id_to_ex_bus,
    output logic [c_ex_to_mem_wd-1:0] ex_to_mem_bus,
    output logic [c_ex_to_rf_wd-1:0]  ex_to_rf_bus,
    output logic                      data_sram_en,
    output logic [3:0]                data_sram_wen,
    output logic [31:0]               data_sram_addr,
    output logic [31:0]               data_sram_wdata,
    output logic                      stallreq_for_ex
);

    id_ex_t      r_id;
    ex_mem_t     w_mem;
    ex_rf_t      w_rf;

    logic [31:0] w_src1;
    logic [31:0] w_src2;
    logic [31:0] w_result;
    logic [31:0] w_add, w_sub, w_slt, w_sltu, w_and, w_nor, w_or, w_xor;
    logic [31:0] w_sll, w_srl, w_sra, w_lui;
    logic [31:0] w_simm, w_zimm, w_sa;

    logic        w_is_div;
    logic        w_div_signed;
    logic        w_div_busy;
    logic        w_div_done;
    logic [31:0] w_div_q;
    logic [31:0] w_div_r;
    logic        w_unused;

    // ID/EX register: bubble when ID stops but EX moves, latch when ID moves
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_id <= '0;
        end else if (stall[2] == c_stop && stall[3] == c_no_stop) begin
            r_id <= '0;
        end else if (stall[2] == c_no_stop) begin
            r_id <= id_ex_t'(id_to_ex_bus);
        end
    end

    assign w_simm = {{16{r_id.inst[15]}}, r_id.inst[15:0]};
    assign w_zimm = {16'h0000, r_id.inst[15:0]};
    assign w_sa   = {27'd0, r_id.inst[10:6]};

    // One-hot AND-OR operand selects; no select yields zero
    assign w_src1 = ({32{r_id.src1[c_src1_rs]}}   & r_id.rdata1)
                  | ({32{r_id.src1[c_src1_pc]}}   & r_id.pc)
                  | ({32{r_id.src1[c_src1_sa]}}   & w_sa);
    assign w_src2 = ({32{r_id.src2[c_src2_rt]}}   & r_id.rdata2)
                  | ({32{r_id.src2[c_src2_simm]}} & w_simm)
                  | ({32{r_id.src2[c_src2_8]}}    & 32'd8)
                  | ({32{r_id.src2[c_src2_zimm]}} & w_zimm);

    assign w_add  = w_src1 + w_src2;
    assign w_sub  = w_src1 - w_src2;
    assign w_slt  = {31'd0, $signed(w_src1) < $signed(w_src2)};
    assign w_sltu = {31'd0, w_src1 < w_src2};
    assign w_and  = w_src1 & w_src2;
    assign w_nor  = ~(w_src1 | w_src2);
    assign w_or   = w_src1 | w_src2;
    assign w_xor  = w_src1 ^ w_src2;
    assign w_sll  = w_src2 << w_src1[4:0];
    assign w_srl  = w_src2 >> w_src1[4:0];
    assign w_sra  = $signed(w_src2) >>> w_src1[4:0];
    assign w_lui  = {r_id.inst[15:0], 16'h0000};

    assign w_result = ({32{r_id.alu_op[c_alu_add]}}  & w_add)
                    | ({32{r_id.alu_op[c_alu_sub]}}  & w_sub)
                    | ({32{r_id.alu_op[c_alu_slt]}}  & w_slt)
                    | ({32{r_id.alu_op[c_alu_sltu]}} & w_sltu)
                    | ({32{r_id.alu_op[c_alu_and]}}  & w_and)
                    | ({32{r_id.alu_op[c_alu_nor]}}  & w_nor)
                    | ({32{r_id.alu_op[c_alu_or]}}   & w_or)
                    | ({32{r_id.alu_op[c_alu_xor]}}  & w_xor)
                    | ({32{r_id.alu_op[c_alu_sll]}}  & w_sll)
                    | ({32{r_id.alu_op[c_alu_srl]}}  & w_srl)
                    | ({32{r_id.alu_op[c_alu_sra]}}  & w_sra)
                    | ({32{r_id.alu_op[c_alu_lui]}}  & w_lui);

    assign w_is_div     = is_div_inst(r_id.inst);
    assign w_div_signed = (r_id.inst[5:0] == c_func_div);

    div_r2 #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_is_div),
        .i_signed (w_div_signed),
        .i_a      (r_id.rdata1),
        .i_b      (r_id.rdata2),
        .i_ack    (stall[3] == c_no_stop),
        .o_busy   (w_div_busy),
        .o_done   (w_div_done),
        .o_q      (w_div_q),
        .o_r      (w_div_r)
    );

    assign stallreq_for_ex = w_div_busy;

    // Memory request is suppressed while the divider holds the pipeline
    assign data_sram_en    = r_id.ram_en & ~w_div_busy;
    assign data_sram_wen   = r_id.ram_wen & {4{~w_div_busy}};
    assign data_sram_addr  = w_result;
    assign data_sram_wdata = r_id.rdata2;

    // Loads cannot forward from EX: their data only exists after MEM
    assign w_rf.we    = r_id.rf_we & ~r_id.sel_rf_res;
    assign w_rf.waddr = r_id.rf_waddr;
    assign w_rf.wdata = w_result;
    assign ex_to_rf_bus = w_rf;

    assign w_mem.pc         = r_id.pc;
    assign w_mem.ram_en     = r_id.ram_en;
    assign w_mem.ram_wen    = r_id.ram_wen;
    assign w_mem.sel_rf_res = r_id.sel_rf_res;
    assign w_mem.rf_we      = r_id.rf_we;
    assign w_mem.rf_waddr   = r_id.rf_waddr;
    assign w_mem.result     = w_result;
    assign w_mem.hi_we      = w_div_done;
    assign w_mem.lo_we      = w_div_done;
    assign w_mem.hi         = w_div_r;
    assign w_mem.lo         = w_div_q;
    assign ex_to_mem_bus    = w_mem;

    assign w_unused = &{1'b0, stall[5:4], stall[1:0], r_id.inst[25:16]};

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_stage
//  Description : Self-checking bench for ex_stage: directed and random ALU,
//                memory, forwarding, stall and divider scenarios against a
//                plain-arithmetic reference.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [158:0] id_bus;
    logic [141:0] mem_bus;
    logic [37:0]  rf_bus;
    logic         sram_en;
    logic [3:0]   sram_wen;
    logic [31:0]  sram_addr;
    logic [31:0]  sram_wdata;
    logic         stallreq;
    logic         ovr_en;
    logic [5:0]   ovr;
    int           n_assert = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    // Pipeline control stand-in: divider stall freezes stages 0..3
    assign stall = ovr_en ? ovr : (stallreq ? 6'b001111 : 6'b000000);

    ex_stage #(.DIV_CYCLES(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_bus),
        .ex_to_mem_bus   (mem_bus),
        .ex_to_rf_bus    (rf_bus),
        .data_sram_en    (sram_en),
        .data_sram_wen   (sram_wen),
        .data_sram_addr  (sram_addr),
        .data_sram_wdata (sram_wdata),
        .stallreq_for_ex (stallreq)
    );

    function automatic logic [158:0] mk(
        input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] alu,
        input logic [2:0] s1, input logic [3:0] s2, input logic ram_en,
        input logic [3:0] wen, input logic rf_we, input logic [4:0] wa,
        input logic sel, input logic [31:0] r1, input logic [31:0] r2);
        return {pc, inst, alu, s1, s2, ram_en, wen, rf_we, wa, sel, r1, r2};
    endfunction

    // Reference ALU: op index 0..11 = add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui
    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] x,
                                            input logic [31:0] y, input logic [15:0] imm);
        case (op)
            0:  return x + y;
            1:  return x - y;
            2:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3:  return (x < y) ? 32'd1 : 32'd0;
            4:  return x & y;
            5:  return ~(x | y);
            6:  return x | y;
            7:  return x ^ y;
            8:  return y << x[4:0];
            9:  return y >> x[4:0];
            10: return $signed(y) >>> x[4:0];
            default: return {imm, 16'h0000};
        endcase
    endfunction

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic mem_probe, input logic hold_probe);
        logic [31:0]  q, r, pc, inst;
        logic [3:0]   wen;
        logic [141:0] exp_bus;
        longint       sa, sb, lq, lr;
        int           cnt;
        pc   = $urandom;
        inst = {6'h00, 5'd4, 5'd5, 10'h000, sgn ? 6'h1A : 6'h1B};
        wen  = mem_probe ? 4'hF : 4'h0;
        id_bus = mk(pc, inst, 12'h000, 3'b000, 4'b0000, mem_probe, wen,
                    1'b0, 5'd0, 1'b0, a, b);
        tick();
        if (mem_probe) check("div_sram_gated", {sram_en, sram_wen}, 5'h00);
        cnt = 0;
        while (stallreq === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        check("div_stall_cycles", cnt, 33);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
        exp_bus = {pc, mem_probe, wen, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, r, q};
        check("div_result", mem_bus, exp_bus);
        if (hold_probe) begin
            ovr_en = 1'b1;
            ovr    = 6'b001111;
            tick();
            check("div_done_hold", {mem_bus, stallreq}, {exp_bus, 1'b0});
            ovr_en = 1'b0;
        end
        id_bus = '0;
        tick();
        check("div_release", {mem_bus, stallreq}, '0);
    endtask

    initial begin
        logic [31:0]  pc, inst, r1, r2, x, y, res;
        logic [141:0] exp_store;
        logic         ram_en, rf_we, sel;
        logic [3:0]   wen;
        logic [4:0]   wa;
        int           k, k1, k2;

        // ---- reset state
        rst    = 1'b0;
        ovr_en = 1'b0;
        ovr    = '0;
        id_bus = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom[30:0]};
        repeat (2) tick();
        check("reset_mem_bus", mem_bus, '0);
        check("reset_side", {rf_bus, sram_en, sram_wen, sram_addr, sram_wdata, stallreq}, '0);
        rst = 1'b1;

        // ---- ori with zero-extended immediate, forwarded same cycle
        id_bus = mk(32'h0040_0000, {6'h0D, 5'd1, 5'd5, 16'h0034}, 12'h800 >> 6,
                    3'b001, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'h0000_1200, 32'h5555_AAAA);
        tick();
        check("ori_rf_bus", rf_bus, {1'b1, 5'd5, 32'h0000_1234});
        check("ori_mem_bus", mem_bus,
              {32'h0040_0000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 2'b00, 64'h0});

        // ---- store word: address = rs + simm, data = rt
        id_bus = mk(32'h0040_0004, {6'h2B, 5'd1, 5'd2, 16'h0004}, 12'h800,
                    3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h0000_0100, 32'hCAFE_F00D);
        tick();
        exp_store = {32'h0040_0004, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h0000_0104, 2'b00, 64'h0};
        check("store_sram", {sram_en, sram_wen, sram_addr, sram_wdata},
              {1'b1, 4'hF, 32'h0000_0104, 32'hCAFE_F00D});
        check("store_no_fwd", rf_bus[37], 1'b0);

        // ---- ID and EX both stopped: register holds
        ovr_en = 1'b1;
        ovr    = 6'b001100;
        id_bus = mk(32'h0040_0008, {6'h0D, 5'd1, 5'd5, 16'h0034}, 12'h800 >> 6,
                    3'b001, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'h1, 32'h2);
        tick();
        check("stall_hold", mem_bus, exp_store);

        // ---- ID stopped, EX moving: bubble
        ovr = 6'b000100;
        tick();
        check("bubble_mem_bus", mem_bus, '0);
        check("bubble_sram_en", sram_en, 1'b0);
        ovr_en = 1'b0;

        // ---- load: no forwarding from EX
        id_bus = mk(32'h0040_000C, {6'h23, 5'd1, 5'd7, 16'h0010}, 12'h800,
                    3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd7, 1'b1, 32'h0000_0200, 32'h0);
        tick();
        check("load_rf_bus", rf_bus, {1'b0, 5'd7, 32'h0000_0210});
        check("load_sram", {sram_en, sram_wen, sram_addr}, {1'b1, 4'h0, 32'h0000_0210});

        // ---- random ALU operations
        for (int i = 0; i < 40; i++) begin
            k      = int'($urandom_range(0, 11));
            k1     = int'($urandom_range(0, 2));
            k2     = int'($urandom_range(0, 3));
            pc     = $urandom;
            inst   = $urandom;
            inst[31:26] = 6'($urandom_range(1, 63));
            r1     = $urandom;
            r2     = $urandom;
            ram_en = 1'($urandom);
            wen    = 4'($urandom);
            rf_we  = 1'($urandom);
            sel    = 1'($urandom);
            wa     = 5'($urandom);
            case (k1)
                0:       x = r1;
                1:       x = pc;
                default: x = {27'd0, inst[10:6]};
            endcase
            case (k2)
                0:       y = r2;
                1:       y = {{16{inst[15]}}, inst[15:0]};
                2:       y = 32'd8;
                default: y = {16'd0, inst[15:0]};
            endcase
            res = ref_alu(k, x, y, inst[15:0]);
            id_bus = mk(pc, inst, 12'h800 >> k, 3'b001 << k1, 4'b0001 << k2,
                        ram_en, wen, rf_we, wa, sel, r1, r2);
            tick();
            check("alu_mem_bus", mem_bus,
                  {pc, ram_en, wen, sel, rf_we, wa, res, 2'b00, 64'h0});
            check("alu_side", {rf_bus, sram_en, sram_wen, sram_addr, sram_wdata, stallreq},
                  {rf_we & ~sel, wa, res, ram_en, wen, res, r2, 1'b0});
        end

        // ---- divider directed cases
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2,         1'b1, 1'b1);
        do_div(1'b0, 32'hFFFF_FFFF, 32'h10,        1'b0, 1'b0);
        do_div(1'b1, 32'd5,         32'd0,         1'b0, 1'b0);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_div(1'b0, 32'h0000_1234, 32'd0,         1'b0, 1'b0);
        do_div(1'b1, 32'hFFFF_FF00, 32'd0,         1'b0, 1'b0);

        // ---- divider random cases
        for (int i = 0; i < 6; i++) begin
            r1 = $urandom;
            r2 = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 15));
            if (i == 5) r2 = 32'hFFFF_FFF3;
            do_div(1'($urandom), r1, r2, 1'b0, 1'b0);
        end

        // ---- reset in the middle of a divide
        id_bus = mk(32'h0040_0100, {6'h00, 5'd4, 5'd5, 10'h000, 6'h1A}, 12'h000,
                    3'b000, 4'b0000, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'd100, 32'd7);
        tick();
        repeat (11) @(posedge clk);
        #1;
        check("midrun_busy", stallreq, 1'b1);
        rst = 1'b0;
        #1;
        check("midrun_reset_mem", mem_bus, '0);
        check("midrun_reset_side", {rf_bus, sram_en, sram_wen, sram_addr, sram_wdata, stallreq}, '0);
        tick();
        rst = 1'b1;
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
